pow2_seq: RTL and testbench
===========================

// Module: pow2_seq
//
// PURPOSE
//  Sequential inverse of log2: takes a bit index (degree) and returns the one-hot
//  word 2**degree, built by shifting a single 1 left once per clock.
//  Valid/ready handshake on both sides; one transaction in flight at a time.
//  Feeds one-hot selects downstream; paired with log2 for round-trip checks.
//
// PARAMETERS
//  WIDTH  8                  one-hot output width; must be a power of two >= 2
//  DEG_W  $clog2(WIDTH) = 3  degree width (derived, do not override)
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      degree presented
//  in_ready   out  1      block can accept a degree
//  in_degree  in   DEG_W  requested bit index, 0..WIDTH-1
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out_data   out  WIDTH  one-hot result, 1 << degree
//  out_degree out  DEG_W  echo of accepted degree
//
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, out_data=0,
//    out_degree=0, counter=0. Takes effect immediately, also mid-shift; the
//    in-flight transaction is discarded, nothing is output for it.
//  - FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE), out_valid = (state==DONE).
//  - IDLE: on in_valid&in_ready at edge E0: out_data<=1, out_degree<=in_degree,
//    cnt<=in_degree; next state DONE if in_degree==0, else SHIFT.
//  - SHIFT: each edge out_data<=out_data<<1, cnt<=cnt-1; when cnt==1 -> DONE.
//  - Latency: out_valid visible after edge E0+d (d=degree); d=0 -> right after E0.
//    Busy time is exactly d shift cycles, independent of out_ready.
//  - DONE: out_data/out_degree held stable while out_valid=1 and out_ready=0.
//    On out_ready=1 at an edge -> IDLE (out_data keeps last value; only valid drops).
//  - in_valid while not IDLE is ignored (no buffering); no new accept in the same
//    cycle as the output handshake -> max throughput one result per d+2 cycles.
//  - out_data always exactly one-hot while out_valid=1; never shifts past bit
//    WIDTH-1 (cnt bound guarantees it).
//  - No combinational path from in_* to out_* or from out_ready to in_ready.
//
// STRUCTURE
//  - Shared package pow2_pkg: state localparams (IDLE=2'd0, SHIFT=2'd1,
//    DONE=2'd2), shared with any future one-hot/log helpers.
//  - Single module; state register, DEG_W-bit down-counter, WIDTH-bit shift
//    register. No sub-module needed.
//
// TESTING
//  1. degrees 0..7, out_ready=1 -> out_data 1,2,4,...,128, out_valid rises d
//     cycles after accept edge, out_degree echoes d.
//  2. degree 5, out_ready=0 for 6 cycles -> out_valid/out_data=32 held stable,
//     in_ready=0 throughout; release -> IDLE next cycle, in_ready=1.
//  3. accept degree 7, pulse in_valid with degree 2 during SHIFT -> ignored;
//     result 128 only.
//  4. accept degree 6, drop rst_n after 3 shift cycles -> immediate IDLE,
//     out_valid=0, out_data=0; next accept of 1 -> out_data=2.
//  5. back-to-back in_valid=1 with degrees 3 then 0 -> results 8 then 1, in order,
//     no loss.
//  6. round trip: out_data into log2 instance for all degrees -> log2 degree
//     equals in_degree.

Source files
------------

// File: rtl/pow2_pkg.sv
// rtl/pow2_pkg.sv - shared state encoding for the one-hot/log sequencers
package pow2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pow2_seq.sv
// rtl/pow2_seq.sv - sequential 2**degree generator, one left shift per clock
module pow2_seq
  import pow2_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int DEG_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEG_W-1:0] in_degree,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DEG_W-1:0] out_degree
);

  state_t           state, state_n;
  logic [DEG_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = (in_degree == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == DEG_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The counter starts at the degree, so the single 1 stops exactly at bit degree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_degree <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data   <= WIDTH'(1);
            out_degree <= in_degree;
            cnt        <= in_degree;
          end
        end
        SHIFT: begin
          out_data <= {out_data[WIDTH-2:0], 1'b0};
          cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow2_seq.sv
// tb/tb_pow2_seq.sv - self-checking bench for pow2_seq with a timestamp-based reference model
module tb_pow2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_degree = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_degree;

  int n_checks = 0;
  int n_fail = 0;

  pow2_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_degree(in_degree),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_degree(out_degree)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int log2_of(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference: a transaction is described by its accept edge number and degree;
  // it becomes visible at accept+degree and leaves on the first edge with out_ready.
  int         cyc = 0;
  bit         pending = 0;
  int         acc_edge = 0;
  int         valid_from = 0;
  int         m_deg = 0;
  logic [7:0] last_data = '0;
  logic [2:0] last_deg = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; pending = 0; last_data = '0; last_deg = '0;
    end else begin
      bit v;
      v = pending && (cyc >= valid_from);
      cyc++;
      if (v && out_ready) begin
        pending   = 0;
        last_data = 8'(1) << m_deg;
        last_deg  = 3'(m_deg);
      end else if (!pending && in_valid) begin
        pending    = 1;
        m_deg      = int'(in_degree);
        acc_edge   = cyc;
        valid_from = cyc + int'(in_degree);
      end
    end
  end

  always @(negedge clk) begin
    bit         e_valid;
    logic [7:0] e_data;
    logic [2:0] e_deg;
    e_valid = pending && (cyc >= valid_from);
    if (!pending)     e_data = last_data;
    else if (e_valid) e_data = 8'(1) << m_deg;
    else              e_data = 8'(1) << (cyc - acc_edge);
    e_deg = pending ? 3'(m_deg) : last_deg;
    check("in_ready", 32'(in_ready), 32'(!pending));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_data", 32'(out_data), 32'(e_data));
    check("out_degree", 32'(out_degree), 32'(e_deg));
    if (out_valid) check("onehot", 32'($countones(out_data)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one degree, measure latency, hold the result for `hold` cycles, then drain.
  task automatic txn(input logic [2:0] d, input int hold, input logic [7:0] exp_data);
    int k;
    in_valid = 1'b1; in_degree = d; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(d));
    check("result", 32'(out_data), 32'(exp_data));
    check("echo", 32'(out_degree), 32'(d));
    check("log2_roundtrip", 32'(log2_of(out_data)), 32'(d));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_data", 32'(out_data), 32'(exp_data));
      check("held_busy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_idle", 32'(in_ready), 32'd1);
    check("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] lit [8] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    logic [7:0] got [$];
    int         nacc;
    bit         acc;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_degree", 32'(out_degree), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int d = 0; d < 8; d++) txn(3'(d), 0, lit[d]);

    txn(3'd5, 6, 8'd32);

    in_valid = 1'b1; in_degree = 3'd7;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_degree = 3'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("ignore_result", 32'(out_data), 32'd128);
    check("ignore_echo", 32'(out_degree), 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ignore_no_extra", 32'(out_valid), 32'd0);
    tick(); tick();
    check("ignore_still_idle", 32'(in_ready), 32'd1);

    in_valid = 1'b1; in_degree = 3'd6;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    txn(3'd1, 1, 8'd2);

    in_valid = 1'b1; in_degree = 3'd3; out_ready = 1'b1;
    nacc = 0;
    for (int i = 0; i < 30; i++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nacc++;
        in_degree = 3'd0;
      end
      if (nacc == 2) in_valid = 1'b0;
      if (out_valid) got.push_back(out_data);
    end
    out_ready = 1'b0;
    check("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("b2b_first", 32'(got[0]), 32'd8);
      check("b2b_second", 32'(got[1]), 32'd1);
    end

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_degree = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
